// File: rtl/sprite_blit_writer.sv
// Copies a SPRITE_W x SPRITE_H block of palette indices into the overlay RAM at (x,y).
// Transparent pixels are skipped and the sprite is clipped at the destination edges.
module sprite_blit_writer #(
  parameter int SPRITE_W          = 100,
  parameter int SPRITE_H          = 100,
  parameter int DST_W             = 640,
  parameter int DST_H             = 480,
  parameter int DATA_WIDTH        = 9,
  parameter int TRANSPARENT_INDEX = 0,
  parameter int SRC_ADDR_WIDTH    = $clog2(SPRITE_W*SPRITE_H)+1,
  parameter int DST_ADDR_WIDTH    = $clog2(DST_W*DST_H)+1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [9:0]                xcoordinate,
  input  logic [8:0]                ycoordinate,
  output logic                      busy,
  output logic                      done,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     src_data,
  output logic [DST_ADDR_WIDTH-1:0] dst_addr,
  output logic [DATA_WIDTH-1:0]     dst_data,
  output logic                      dst_wEn
);

  localparam int COL_W = $clog2(SPRITE_W+1);
  localparam int ROW_W = $clog2(SPRITE_H+1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FINISH = 2'd3} state_t;

  state_t                    state_r, state_next_s;
  logic                      drain_cnt_r, busy_r, done_r;
  logic                      issue_s, last_issue_s, write_ok_s;
  logic [9:0]                x_r;
  logic [8:0]                y_r;
  logic [COL_W-1:0]          col_r;
  logic [ROW_W-1:0]          row_r;
  logic [SRC_ADDR_WIDTH-1:0] src_addr_r;
  logic [DST_ADDR_WIDTH-1:0] row_base_r;
  logic                      s1_valid_r;
  logic [10:0]               s1_xsum_r;
  logic [9:0]                s1_ysum_r;
  logic [DST_ADDR_WIDTH-1:0] s1_addr_r;
  logic [DST_ADDR_WIDTH-1:0] dst_addr_r;
  logic [DATA_WIDTH-1:0]     dst_data_r;
  logic                      dst_wen_r;

  // Next-state decode and issue qualification
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    last_issue_s = (col_r == COL_W'(SPRITE_W-1)) && (row_r == ROW_W'(SPRITE_H-1));
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        issue_s = 1'b1;
        if (last_issue_s) state_next_s = DRAIN;
        else              state_next_s = RUN;
      end
      DRAIN: begin
        if (drain_cnt_r) state_next_s = FINISH;
        else             state_next_s = DRAIN;
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register with registered busy/done flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      drain_cnt_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
      busy_r      <= (state_next_s == RUN) || (state_next_s == DRAIN);
      done_r      <= (state_next_s == FINISH);
    end
  end

  // Coordinate latch and incremental source/destination address walk
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r        <= 10'd0;
      y_r        <= 9'd0;
      col_r      <= '0;
      row_r      <= '0;
      src_addr_r <= '0;
      row_base_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x_r        <= xcoordinate;
            y_r        <= ycoordinate;
            col_r      <= '0;
            row_r      <= '0;
            src_addr_r <= '0;
            // One-off product at launch; the per-pixel loop only adds.
            row_base_r <= DST_ADDR_WIDTH'(ycoordinate) * DST_ADDR_WIDTH'(DST_W)
                          + DST_ADDR_WIDTH'(xcoordinate);
          end
        end
        RUN: begin
          if (!last_issue_s) src_addr_r <= src_addr_r + SRC_ADDR_WIDTH'(1);
          if (col_r == COL_W'(SPRITE_W-1)) begin
            col_r      <= '0;
            row_r      <= row_r + ROW_W'(1);
            row_base_r <= row_base_r + DST_ADDR_WIDTH'(DST_W);
          end else begin
            col_r <= col_r + COL_W'(1);
          end
        end
        default: begin
          src_addr_r <= src_addr_r;
        end
      endcase
    end
  end

  // Stage 1: delay column/row info to line up with the RAM read data
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_xsum_r  <= 11'd0;
      s1_ysum_r  <= 10'd0;
      s1_addr_r  <= '0;
    end else begin
      s1_valid_r <= issue_s;
      s1_xsum_r  <= {1'b0, x_r} + 11'(col_r);
      s1_ysum_r  <= {1'b0, y_r} + 10'(row_r);
      s1_addr_r  <= row_base_r + DST_ADDR_WIDTH'(col_r);
    end
  end

  // Drop transparent and off-screen pixels; wide sums keep clipping wrap-free
  always_comb begin
    write_ok_s = 1'b0;
    if (s1_valid_r && (src_data != DATA_WIDTH'(TRANSPARENT_INDEX)) &&
        (s1_xsum_r < 11'(DST_W)) && (s1_ysum_r < 10'(DST_H))) begin
      write_ok_s = 1'b1;
    end else begin
      write_ok_s = 1'b0;
    end
  end

  // Stage 2: registered overlay write port
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_wen_r  <= 1'b0;
      dst_addr_r <= '0;
      dst_data_r <= '0;
    end else begin
      dst_wen_r <= write_ok_s;
      if (write_ok_s) begin
        dst_addr_r <= s1_addr_r;
        dst_data_r <= src_data;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign src_addr = src_addr_r;
  assign dst_addr = dst_addr_r;
  assign dst_data = dst_data_r;
  assign dst_wEn  = dst_wen_r;

endmodule

// File: tb/tb_sprite_blit_writer.sv
// Scoreboard bench for sprite_blit_writer: a pixel-level model predicts every overlay write,
// busy window and done pulse; a negedge monitor compares against what the DUT presents.
module tb_sprite_blit_writer;
  localparam int SW = 4, SH = 3, DW = 8, DH = 6, DATA_W = 9, NPIX = SW*SH;
  localparam int SAW = $clog2(SW*SH)+1;
  localparam int DAW = $clog2(DW*DH)+1;
  localparam int NO_ABORT = 1000;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [9:0] xcoord = 10'd0;
  logic [8:0] ycoord = 9'd0;
  logic busy, done, dst_wEn;
  logic [SAW-1:0] src_addr;
  logic [DATA_W-1:0] src_data = '0, dst_data;
  logic [DAW-1:0] dst_addr;

  sprite_blit_writer #(.SPRITE_W(SW), .SPRITE_H(SH), .DST_W(DW), .DST_H(DH),
                       .DATA_WIDTH(DATA_W), .TRANSPARENT_INDEX(0)) dut (
    .clk(clk), .reset(reset), .start(start), .xcoordinate(xcoord), .ycoordinate(ycoord),
    .busy(busy), .done(done), .src_addr(src_addr), .src_data(src_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_wEn(dst_wEn));

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [DATA_W-1:0] sprite_mem [NPIX];
  always @(posedge clk) begin
    if (src_addr < SAW'(NPIX)) src_data <= sprite_mem[src_addr[3:0]];
    else                       src_data <= '0;
  end

  typedef struct {int cyc; int addr; int data;} wr_t;
  typedef struct {int t0; int hi;} win_t;
  wr_t  wr_q[$];
  int   done_q[$];
  win_t win_q[$];

  int checks = 0, fails = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: which pixels land where, and when, for a blit started in cycle t0.
  // Outputs from cycle abort_rel onward are suppressed by a reset.
  task automatic expect_blit(input int x, input int y, input int t0, input int abort_rel);
    win_t w;
    for (int p = 0; p < NPIX; p++) begin
      int row, col, px, py, d, rel;
      row = p / SW; col = p % SW; rel = 3 + p;
      px = x + col; py = y + row; d = int'(sprite_mem[p]);
      if (rel < abort_rel && d != 0 && px < DW && py < DH)
        wr_q.push_back('{cyc: t0 + rel, addr: py*DW + px, data: d});
    end
    if (abort_rel > NPIX + 3) done_q.push_back(t0 + NPIX + 3);
    w.t0 = t0;
    w.hi = (abort_rel - 1 < NPIX + 2) ? abort_rel - 1 : NPIX + 2;
    win_q.push_back(w);
  endtask

  bit busy_exp;
  int rel_c;
  wr_t e;

  always @(negedge clk) begin
    if (mon_en) begin
      busy_exp = 1'b0;
      while (win_q.size() > 0 && win_q[0].t0 + win_q[0].hi < edge_cnt) void'(win_q.pop_front());
      if (win_q.size() > 0 && edge_cnt >= win_q[0].t0 + 1) begin
        busy_exp = 1'b1;
        rel_c = edge_cnt - win_q[0].t0;
        if (rel_c <= NPIX) chk("src_addr", int'(src_addr), rel_c - 1);
      end
      chk("busy", int'(busy), int'(busy_exp));
      while (wr_q.size() > 0 && wr_q[0].cyc < edge_cnt) begin
        checks++; fails++;
        $display("FAIL missed_write: no write seen, expected addr %0d data %0d", wr_q[0].addr, wr_q[0].data);
        void'(wr_q.pop_front());
      end
      if (dst_wEn) begin
        if (wr_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL extra_write: got addr %0d data %0d, expected no write", dst_addr, dst_data);
        end else begin
          e = wr_q.pop_front();
          chk("write_cycle", edge_cnt, e.cyc);
          chk("write_addr", int'(dst_addr), e.addr);
          chk("write_data", int'(dst_data), e.data);
        end
      end
      while (done_q.size() > 0 && done_q[0] < edge_cnt) begin
        checks++; fails++;
        $display("FAIL missed_done: no done seen, expected at %0d", done_q[0]);
        void'(done_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL extra_done: got done at %0d, expected none", edge_cnt);
        end else begin
          chk("done_cycle", edge_cnt, done_q.pop_front());
        end
      end
    end
  end

  task automatic run_blit(input int x, input int y);
    int t0;
    xcoord = 10'(x); ycoord = 9'(y); start = 1'b1;
    t0 = edge_cnt;
    expect_blit(x, y, t0, NO_ABORT);
    @(negedge clk) start = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int t0;
    for (int p = 0; p < NPIX; p++) sprite_mem[p] = DATA_W'(p + 1);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wen", int'(dst_wEn), 0);
    chk("rst_src_addr", int'(src_addr), 0);
    chk("rst_dst_addr", int'(dst_addr), 0);
    chk("rst_dst_data", int'(dst_data), 0);
    reset = 1'b0;
    @(negedge clk) mon_en = 1'b1;

    run_blit(2, 1);                         // basic
    sprite_mem[0] = '0; sprite_mem[5] = '0; sprite_mem[10] = '0;
    run_blit(0, 0);                         // transparency
    for (int p = 0; p < NPIX; p++) sprite_mem[p] = DATA_W'(p + 1);
    run_blit(6, 4);                         // clipping
    run_blit(640, 0);                       // fully off-screen

    // start held through a blit, coordinates changed mid-blit
    xcoord = 10'd1; ycoord = 9'd0; start = 1'b1;
    t0 = edge_cnt;
    expect_blit(1, 0, t0, NO_ABORT);
    expect_blit(3, 2, t0 + 16, NO_ABORT);
    repeat (5) @(negedge clk);
    xcoord = 10'd3; ycoord = 9'd2;
    repeat (12) @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);

    // reset in cycle 6 of a blit
    xcoord = 10'd1; ycoord = 9'd1; start = 1'b1;
    t0 = edge_cnt;
    expect_blit(1, 1, t0, 7);
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("post_rst_wen", int'(dst_wEn), 0);
    chk("post_rst_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    run_blit(2, 2);

    // randomized sprites and positions, including partial clipping
    for (int k = 0; k < 5; k++) begin
      for (int p = 0; p < NPIX; p++)
        sprite_mem[p] = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom_range(1, 511));
      run_blit(int'($urandom_range(0, 9)), int'($urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    chk("writes_drained", wr_q.size(), 0);
    chk("dones_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
